// File: rtl/ldpc_cnu_sched_if.sv
// Scheduler <-> decoder handshake bundle: start/done, CNU issue and write-back, variable-node handshake.
// The master side is the decoder top / PE array; the slave side is ldpc_cnu_sched.
interface ldpc_cnu_sched_if #(
    parameter int NUM_ROWS = 12,
    parameter int MAX_ITER = 10
);
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int ITER_W = $clog2(MAX_ITER + 1);

    logic              start;
    logic              busy;
    logic              cnu_en;
    logic [ROW_W-1:0]  row_addr;
    logic              p_bit;
    logic              wb_en;
    logic [ROW_W-1:0]  wb_addr;
    logic              var_start;
    logic              var_done;
    logic              done;
    logic              converged;
    logic [ITER_W-1:0] iter_count;
    logic [ROW_W:0]    unsat_cnt;

    modport master (
        output start, p_bit, var_done,
        input  busy, cnu_en, row_addr, wb_en, wb_addr, var_start,
               done, converged, iter_count, unsat_cnt
    );

    modport slave (
        input  start, p_bit, var_done,
        output busy, cnu_en, row_addr, wb_en, wb_addr, var_start,
               done, converged, iter_count, unsat_cnt
    );
endinterface

// File: rtl/ldpc_cnu_sched.sv
// LDPC iteration scheduler: time-shares one CNU over all check rows, tracks the syndrome, and
// hands off to the variable-node update. Define CTRL_EARLY_TERM_EN to stop on a zero syndrome.
module ldpc_cnu_sched #(
    parameter int NUM_ROWS = 12,
    parameter int MAX_ITER = 10
) (
    input logic            clk,
    input logic            rst,
    ldpc_cnu_sched_if.slave bus
);
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam int CNT_W  = ROW_W + 1;

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);
    localparam logic [ITER_W-1:0] ITER_LIM  = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DRAIN,
        S_VAR,
        S_DONE
    } state_t;

    state_t            state;
    logic              syn_acc;
    logic [CNT_W-1:0]  unsat_acc;

    logic              wb_hit;
    logic              syn_final;
    logic [CNT_W-1:0]  unsat_final;
    logic              stop_early;

    // Accumulators as they will stand once this cycle's write-back is folded in, so the DRAIN
    // decision sees the last row's parity without waiting an extra cycle.
    always_comb begin
        wb_hit      = bus.wb_en & bus.p_bit;
        syn_final   = syn_acc | wb_hit;
        unsat_final = unsat_acc + CNT_W'(wb_hit);
    end

`ifdef CTRL_EARLY_TERM_EN
    assign stop_early = ~syn_final;
`else
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            syn_acc        <= 1'b0;
            unsat_acc      <= '0;
            bus.busy       <= 1'b0;
            bus.cnu_en     <= 1'b0;
            bus.row_addr   <= '0;
            bus.wb_en      <= 1'b0;
            bus.wb_addr    <= '0;
            bus.var_start  <= 1'b0;
            bus.done       <= 1'b0;
            bus.converged  <= 1'b0;
            bus.iter_count <= '0;
            bus.unsat_cnt  <= '0;
        end else begin
            bus.wb_en     <= bus.cnu_en;
            bus.wb_addr   <= bus.row_addr;
            bus.var_start <= 1'b0;
            bus.done      <= 1'b0;

            // Row 0 issue never overlaps a write-back (the previous cycle was IDLE or VAR).
            if (bus.cnu_en && bus.row_addr == '0) begin
                syn_acc   <= 1'b0;
                unsat_acc <= '0;
            end else if (bus.wb_en) begin
                syn_acc   <= syn_final;
                unsat_acc <= unsat_final;
            end

            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state          <= S_CHECK;
                        bus.busy       <= 1'b1;
                        bus.cnu_en     <= 1'b1;
                        bus.row_addr   <= '0;
                        bus.iter_count <= '0;
                        bus.converged  <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (bus.row_addr == LAST_ROW) begin
                        state      <= S_DRAIN;
                        bus.cnu_en <= 1'b0;
                    end else begin
                        bus.row_addr <= bus.row_addr + ROW_W'(1);
                    end
                end
                S_DRAIN: begin
                    bus.unsat_cnt <= unsat_final;
                    if (stop_early) begin
                        state         <= S_DONE;
                        bus.done      <= 1'b1;
                        bus.converged <= 1'b1;
                    end else if (bus.iter_count == ITER_LIM) begin
                        state         <= S_DONE;
                        bus.done      <= 1'b1;
                        bus.converged <= ~syn_final;
                    end else begin
                        state         <= S_VAR;
                        bus.var_start <= 1'b1;
                    end
                end
                S_VAR: begin
                    // var_start is high only in the first VAR cycle, which masks a stale var_done.
                    if (!bus.var_start && bus.var_done) begin
                        state          <= S_CHECK;
                        bus.iter_count <= bus.iter_count + ITER_W'(1);
                        bus.cnu_en     <= 1'b1;
                        bus.row_addr   <= '0;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_cnu_sched.sv
// Directed bench for ldpc_cnu_sched: two instances (MAX_ITER=10 and MAX_ITER=4), expectations
// adapt to whether CTRL_EARLY_TERM_EN is defined.
module tb_ldpc_cnu_sched;
    localparam int NUM_ROWS = 12;
    localparam int TRACE    = 16;
    localparam int P_ZERO   = 0;
    localparam int P_ROWS37 = 1;
    localparam int P_LATE   = 2;
`ifdef CTRL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ldpc_cnu_sched_if #(.NUM_ROWS(NUM_ROWS), .MAX_ITER(10)) bus_a ();
    ldpc_cnu_sched_if #(.NUM_ROWS(NUM_ROWS), .MAX_ITER(4))  bus_b ();

    ldpc_cnu_sched #(.NUM_ROWS(NUM_ROWS), .MAX_ITER(10)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ldpc_cnu_sched #(.NUM_ROWS(NUM_ROWS), .MAX_ITER(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    int         n_vs, n_phase, n_busy_low, done_c;
    bit         timed_out, rst_hit, post_busy, post_done, conv_c1;
    logic       fin_conv;
    logic [3:0] fin_iter;
    logic [4:0] fin_unsat;
    logic       tr_cnu [TRACE];
    logic       tr_wb  [TRACE];
    logic [3:0] tr_row [TRACE];
    logic [3:0] tr_wba [TRACE];

    function automatic logic perr(input int mode, input logic [3:0] r, input logic [3:0] it);
        logic hot;
        hot = (r == 4'd3) || (r == 4'd7);
        case (mode)
            P_ROWS37: return hot;
            P_LATE:   return hot && (it < 4'd3);
            default:  return 1'b0;
        endcase
    endfunction

    // Drives one decode on instance A cycle by cycle; var_delay==0 holds var_done high throughout.
    task automatic run_decode(input int mode, input int var_delay, input bit inject,
                              input bit rst_mid, input int budget);
        int c;
        int vs_c;
        n_vs = 0; n_phase = 0; n_busy_low = 0; done_c = -1;
        timed_out = 0; rst_hit = 0; post_busy = 1; post_done = 1; conv_c1 = 1;
        vs_c = -100;
        for (int i = 0; i < TRACE; i++) begin
            tr_cnu[i] = 0; tr_wb[i] = 0; tr_row[i] = 0; tr_wba[i] = 0;
        end
        @(negedge clk);
        bus_a.start = 1; bus_a.p_bit = 0; bus_a.var_done = 0;
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            bus_a.start = 0;
            if (c < TRACE) begin
                tr_cnu[c] = bus_a.cnu_en; tr_row[c] = bus_a.row_addr;
                tr_wb[c]  = bus_a.wb_en;  tr_wba[c] = bus_a.wb_addr;
            end
            if (c == 1) conv_c1 = bus_a.converged;
            if (!bus_a.busy) n_busy_low++;
            if (bus_a.var_start) begin n_vs++; vs_c = c; end
            if (bus_a.cnu_en && bus_a.row_addr == 4'(NUM_ROWS - 1)) n_phase++;
            if (bus_a.done) begin
                done_c = c; fin_conv = bus_a.converged;
                fin_iter = bus_a.iter_count; fin_unsat = bus_a.unsat_cnt;
                bus_a.start = inject;
                @(negedge clk);
                bus_a.start = 0;
                post_busy = bus_a.busy; post_done = bus_a.done;
                break;
            end
            if (rst_mid && bus_a.iter_count == 4'd2 && bus_a.cnu_en && bus_a.row_addr == 4'd5) begin
                rst = 1; rst_hit = 1;
                break;
            end
            if (c >= budget) begin timed_out = 1; break; end
            bus_a.p_bit    = bus_a.wb_en && perr(mode, bus_a.wb_addr, bus_a.iter_count);
            bus_a.var_done = (var_delay == 0) ? 1'b1 : (c == vs_c + var_delay);
            bus_a.start    = inject && bus_a.busy;
        end
        bus_a.p_bit = 0; bus_a.var_done = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        bus_a.start = 0; bus_a.p_bit = 0; bus_a.var_done = 0;
        bus_b.start = 0; bus_b.p_bit = 0; bus_b.var_done = 1;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
        checks++; if ({bus_a.cnu_en, bus_a.wb_en, bus_a.var_start, bus_a.done, bus_a.converged} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000",
                {bus_a.cnu_en, bus_a.wb_en, bus_a.var_start, bus_a.done, bus_a.converged}); end
        checks++; if ({bus_a.row_addr, bus_a.wb_addr, bus_a.iter_count, bus_a.unsat_cnt} !== 17'b0) begin
            errors++; $display("FAIL reset_values: row %0d wb %0d iter %0d unsat %0d want all 0",
                bus_a.row_addr, bus_a.wb_addr, bus_a.iter_count, bus_a.unsat_cnt); end
        rst = 0;
        repeat (2) @(negedge clk);
        checks++; if ({bus_a.busy, bus_a.cnu_en} !== 2'b00) begin
            errors++; $display("FAIL idle_no_start: busy/cnu_en %b want 00", {bus_a.busy, bus_a.cnu_en}); end
    endtask

    task automatic test_early_term();
        int errs0;
        run_decode(P_ZERO, 3, 0, 0, 400);
        errs0 = errors;
        for (int c = 1; c <= 13; c++) begin
            checks++; if (tr_cnu[c] !== (c <= 12)) begin errors++;
                $display("FAIL cnu_en_c%0d: got %b want %b", c, tr_cnu[c], (c <= 12)); end
            if (c <= 12) begin
                checks++; if (tr_row[c] !== 4'(c - 1)) begin errors++;
                    $display("FAIL row_addr_c%0d: got %0d want %0d", c, tr_row[c], c - 1); end
            end
            checks++; if (tr_wb[c] !== (c >= 2)) begin errors++;
                $display("FAIL wb_en_c%0d: got %b want %b", c, tr_wb[c], (c >= 2)); end
            if (c >= 2) begin
                checks++; if (tr_wba[c] !== 4'(c - 2)) begin errors++;
                    $display("FAIL wb_addr_c%0d: got %0d want %0d", c, tr_wba[c], c - 2); end
            end
        end
        if (errors != errs0) $display("first check phase sequence had %0d errors", errors - errs0);
        checks++; if (done_c !== (EARLY ? 14 : 184)) begin errors++;
            $display("FAIL early_done_cycle: got %0d want %0d", done_c, EARLY ? 14 : 184); end
        checks++; if (fin_conv !== 1'b1) begin errors++; $display("FAIL early_converged: got %b want 1", fin_conv); end
        checks++; if (fin_iter !== (EARLY ? 4'd0 : 4'd10)) begin errors++;
            $display("FAIL early_iter: got %0d want %0d", fin_iter, EARLY ? 0 : 10); end
        checks++; if (fin_unsat !== 5'd0) begin errors++; $display("FAIL early_unsat: got %0d want 0", fin_unsat); end
        checks++; if ({post_busy, post_done} !== 2'b00) begin errors++;
            $display("FAIL done_one_cycle: busy/done after DONE %b want 00", {post_busy, post_done}); end
    endtask

    task automatic test_iter_limit();
        run_decode(P_ROWS37, 3, 0, 0, 400);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL limit_timeout: no done within budget"); end
        checks++; if (conv_c1 !== 1'b0) begin errors++; $display("FAIL converged_cleared: got %b want 0", conv_c1); end
        checks++; if (n_vs !== 10) begin errors++; $display("FAIL limit_var_starts: got %0d want 10", n_vs); end
        checks++; if (n_phase !== 11) begin errors++; $display("FAIL limit_phases: got %0d want 11", n_phase); end
        checks++; if (done_c !== 184) begin errors++; $display("FAIL limit_done_cycle: got %0d want 184", done_c); end
        checks++; if (fin_conv !== 1'b0) begin errors++; $display("FAIL limit_converged: got %b want 0", fin_conv); end
        checks++; if (fin_iter !== 4'd10) begin errors++; $display("FAIL limit_iter: got %0d want 10", fin_iter); end
        checks++; if (fin_unsat !== 5'd2) begin errors++; $display("FAIL limit_unsat: got %0d want 2", fin_unsat); end
    endtask

    task automatic test_late_conv();
        run_decode(P_LATE, 3, 0, 0, 400);
        checks++; if (n_phase !== (EARLY ? 4 : 11)) begin errors++;
            $display("FAIL late_phases: got %0d want %0d", n_phase, EARLY ? 4 : 11); end
        checks++; if (done_c !== (EARLY ? 65 : 184)) begin errors++;
            $display("FAIL late_done_cycle: got %0d want %0d", done_c, EARLY ? 65 : 184); end
        checks++; if (fin_conv !== 1'b1) begin errors++; $display("FAIL late_converged: got %b want 1", fin_conv); end
        checks++; if (fin_iter !== (EARLY ? 4'd3 : 4'd10)) begin errors++;
            $display("FAIL late_iter: got %0d want %0d", fin_iter, EARLY ? 3 : 10); end
        checks++; if (fin_unsat !== 5'd0) begin errors++; $display("FAIL late_unsat: got %0d want 0", fin_unsat); end
        repeat (3) @(negedge clk);
        checks++; if ({bus_a.converged, bus_a.unsat_cnt} !== 6'b1_00000) begin errors++;
            $display("FAIL result_held: converged %b unsat %0d want 1/0", bus_a.converged, bus_a.unsat_cnt); end
    endtask

    task automatic test_var_hold();
        run_decode(P_ROWS37, 0, 0, 0, 400);
        checks++; if (done_c !== 164) begin errors++; $display("FAIL var_min_two_cycles: done at %0d want 164", done_c); end
        checks++; if (n_vs !== 10) begin errors++; $display("FAIL var_hold_starts: got %0d want 10", n_vs); end
    endtask

    task automatic test_start_ignored();
        run_decode(P_LATE, 3, 1, 0, 400);
        checks++; if (n_busy_low !== 0) begin errors++; $display("FAIL busy_drop: busy low %0d cycles want 0", n_busy_low); end
        checks++; if (n_phase !== (EARLY ? 4 : 11)) begin errors++;
            $display("FAIL inject_phases: got %0d want %0d", n_phase, EARLY ? 4 : 11); end
        checks++; if (done_c !== (EARLY ? 65 : 184)) begin errors++;
            $display("FAIL inject_done_cycle: got %0d want %0d", done_c, EARLY ? 65 : 184); end
        checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL start_in_done: busy %b want 0", post_busy); end
        @(negedge clk);
        checks++; if ({bus_a.busy, bus_a.cnu_en} !== 2'b00) begin errors++;
            $display("FAIL start_in_done_restart: busy/cnu_en %b want 00", {bus_a.busy, bus_a.cnu_en}); end
    endtask

    task automatic test_reset_mid();
        run_decode(P_ROWS37, 3, 0, 1, 400);
        checks++; if (rst_hit !== 1'b1) begin errors++; $display("FAIL rst_point: row 5 of phase 2 not reached"); end
        @(negedge clk);
        checks++; if ({bus_a.busy, bus_a.cnu_en, bus_a.wb_en, bus_a.done} !== 4'b0000) begin errors++;
            $display("FAIL rst_mid_flags: busy/cnu/wb/done %b want 0000",
                {bus_a.busy, bus_a.cnu_en, bus_a.wb_en, bus_a.done}); end
        checks++; if ({bus_a.iter_count, bus_a.unsat_cnt} !== 9'b0) begin errors++;
            $display("FAIL rst_mid_counts: iter %0d unsat %0d want 0/0", bus_a.iter_count, bus_a.unsat_cnt); end
        rst = 0;
        run_decode(P_ZERO, 3, 0, 0, 400);
        checks++; if (done_c !== (EARLY ? 14 : 184)) begin errors++;
            $display("FAIL rst_fresh_done: got %0d want %0d", done_c, EARLY ? 14 : 184); end
        checks++; if (fin_conv !== 1'b1) begin errors++; $display("FAIL rst_fresh_conv: got %b want 1", fin_conv); end
    endtask

    task automatic test_no_early_term();
        int c;
        int nvs;
        int dc;
        logic       conv;
        logic [2:0] it;
        logic [4:0] un;
        c = 0; nvs = 0; dc = -1; conv = 0; it = '1; un = '1;
        @(negedge clk);
        bus_b.start = 1;
        while (c < 300) begin
            @(negedge clk);
            c++;
            bus_b.start = 0;
            if (bus_b.var_start) nvs++;
            if (bus_b.done) begin
                dc = c; conv = bus_b.converged; it = bus_b.iter_count; un = bus_b.unsat_cnt;
                break;
            end
        end
        checks++; if (dc !== (EARLY ? 14 : 74)) begin errors++;
            $display("FAIL b_done_cycle: got %0d want %0d", dc, EARLY ? 14 : 74); end
        checks++; if (nvs !== (EARLY ? 0 : 4)) begin errors++;
            $display("FAIL b_var_starts: got %0d want %0d", nvs, EARLY ? 0 : 4); end
        checks++; if (conv !== 1'b1) begin errors++; $display("FAIL b_converged: got %b want 1", conv); end
        checks++; if (it !== (EARLY ? 3'd0 : 3'd4)) begin errors++;
            $display("FAIL b_iter: got %0d want %0d", it, EARLY ? 0 : 4); end
        checks++; if (un !== 5'd0) begin errors++; $display("FAIL b_unsat: got %0d want 0", un); end
    endtask

    initial begin
        test_reset();
        test_early_term();
        test_iter_limit();
        test_late_conv();
        test_var_hold();
        test_start_ignored();
        test_reset_mid();
        test_no_early_term();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ldpc_cnu_sched.md
# ldpc_cnu_sched

Iteration scheduler for the LDPC decoder core. It time-shares one CNU across the parity-check rows of the code and sequences each check phase: row addressing, CNU enable, and write-back strobes aligned to the CNU's one-cycle register latency. Between check phases it hands off to the PE/variable-node update through a start/done handshake. It accumulates the CNU parity bit into a syndrome, stops early on a zero syndrome or after the iteration limit, and reports the result to the decoder top level.

## Interface
- NUM_ROWS, 12: number of parity-check rows served by the shared CNU (≥2)
- MAX_ITER, 10: maximum number of variable-node update phases per codeword (≥1)
- ROW_W, $clog2(NUM_ROWS): row address width (derived)
- ITER_W, $clog2(MAX_ITER+1): iteration counter width (derived)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin decoding one codeword; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- cnu_en  out  1  drives CNU `en`; high one cycle per issued row
- row_addr  out  ROW_W  row whose PE messages feed the CNU this cycle
- p_bit  in  1  CNU parity output; valid in the cycle after the matching cnu_en
- wb_en  out  1  CNU outputs valid; PE array writes the CNU messages for wb_addr
- wb_addr  out  ROW_W  row being written back (row_addr delayed one cycle)
- var_start  out  1  one-cycle pulse launching the variable-node update
- var_done  in  1  variable-node update complete
- done  out  1  one-cycle pulse; decoding finished
- converged  out  1  final syndrome was zero; valid from done until next accepted start
- iter_count  out  ITER_W  completed variable-node phases
- unsat_cnt  out  ROW_W+1  rows with p_bit=1 in the most recent complete check phase

## Operation
- States:
  - IDLE
  - CHECK: issue rows 0..NUM_ROWS-1, one per cycle.
  - DRAIN: one cycle, write-back of the last row.
  - VAR: wait for the variable-node update.
  - DONE: one cycle, done=1.
- IDLE to CHECK on start=1:
  - iter_count cleared to 0.
  - converged cleared to 0.
  - Row counter cleared to 0.
- CHECK:
  - cnu_en=1 and row_addr=row counter.
  - After row NUM_ROWS-1, go to DRAIN.
- Write-back pipeline:
  - wb_en is cnu_en registered; wb_addr is row_addr registered.
  - In every cycle with wb_en=1, p_bit is ORed into the syndrome flag and added to the unsat accumulator.
  - Both accumulators clear when row 0 is issued.
- DRAIN decision, taken on the accumulators including the last row's p_bit:
  - Syndrome zero (and CTRL_EARLY_TERM_EN defined): go to DONE with converged=1.
  - Else if iter_count==MAX_ITER: go to DONE; converged = (syndrome==0).
  - Else: go to VAR.
  - unsat_cnt is loaded from the accumulator on the DRAIN cycle.
- VAR:
  - var_start=1 in the first VAR cycle only.
  - var_done is ignored in that first cycle.
  - On var_done=1 in a later cycle: iter_count increments and the state goes to CHECK with row 0.
- DONE: done=1 for one cycle, then IDLE.
- start while busy=1 is ignored. start in the DONE cycle is ignored.
- cnu_en is never high outside CHECK. wb_en is never high outside the cycle after a CHECK cycle.

## Timing
- Reset values:
  - State IDLE.
  - busy, cnu_en, wb_en, var_start, done, converged: 0.
  - row_addr, wb_addr, iter_count, unsat_cnt: 0.
- rst mid-operation: next cycle is IDLE with all reset values. No done pulse. In-flight write-back is dropped.
- start sampled at cycle 0:
  - cnu_en high cycles 1..NUM_ROWS.
  - wb_en high cycles 2..NUM_ROWS+1 (cycle NUM_ROWS+1 = DRAIN).
  - Decision at the end of DRAIN.
- Converged on the first check phase: done=1 at cycle NUM_ROWS+2.
- Each further iteration adds (NUM_ROWS+1) + (VAR cycles, minimum 2).
- All outputs are registered. No combinational path from p_bit or var_done to any output.

## Configuration
- CTRL_EARLY_TERM_EN defined:
  - A zero syndrome at any DRAIN terminates with converged=1.
- CTRL_EARLY_TERM_EN undefined:
  - The syndrome never terminates early.
  - Always exactly MAX_ITER VAR phases and MAX_ITER+1 check phases.
  - converged reflects the final syndrome only; unsat_cnt is still updated every phase.

## Test plan
- Early termination: NUM_ROWS=12, CTRL_EARLY_TERM_EN defined, p_bit=0 always, start at cycle 0.
  - Expect cnu_en in cycles 1..12 with row_addr 0..11.
  - Expect done at cycle 14, converged=1, iter_count=0, unsat_cnt=0.
- Iteration limit: p_bit=1 for rows 3 and 7 every phase, MAX_ITER=10, var_done 3 cycles after each var_start.
  - Expect exactly 10 var_start pulses and 11 check phases.
  - Expect done with converged=0, iter_count=10, unsat_cnt=2.
- Late convergence: p_bit nonzero in phases 0–2, zero from phase 3.
  - Expect done after the 4th DRAIN, converged=1, iter_count=3.
- Handshake corner cases:
  - var_done held high continuously still enforces a 2-cycle minimum VAR.
  - start pulses during CHECK, VAR and DONE are ignored; busy stays 1 and no extra row issue occurs.
- Reset mid-operation: rst=1 at row 5 of phase 2.
  - Next cycle: busy=0, cnu_en=0, wb_en=0, iter_count=0, no done pulse.
  - A fresh start then decodes normally.
- Without CTRL_EARLY_TERM_EN: p_bit=0 always, MAX_ITER=4.
  - Expect 4 var_start pulses, then done with converged=1, iter_count=4.
